// File: rtl/mem_lsu_buffered.sv
// MEM-stage load/store unit: stores post to an in-order buffer, loads go to memctrl after drain.
// Define LSU_STORE_FWD_EN to forward exact-match buffered stores to loads.
module mem_lsu_buffered #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned SB_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_valid_i,
   input  logic              mem_we_i,
   input  logic [2:0]        funct3_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [XLEN-1:0]   wdata_i,
   input  logic [4:0]        rd_addr_i,
   input  logic              rd_we_i,
   input  logic [XLEN-1:0]   rd_data_i,
   input  logic              hold_i,
   output logic [4:0]        rd_addr_o,
   output logic              rd_we_o,
   output logic [XLEN-1:0]   rd_data_o,
   output logic              stallreq_o,
   output logic              req_valid_o,
   input  logic              req_ready_i,
   output logic              req_we_o,
   output logic [ADDR_W-1:0] req_addr_o,
   output logic [1:0]        req_size_o,
   output logic [XLEN-1:0]   req_wdata_o,
   input  logic              resp_valid_i,
   input  logic [XLEN-1:0]   resp_rdata_i,
   output logic              sb_empty_o
);

   localparam int unsigned PTR_W = $clog2(SB_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      StIdle, StStReq, StStWait, StLdReq, StLdWait, StLdDone
   } state_e;

   state_e state_q, state_d;

   function automatic logic [1:0] f3_size(input logic [2:0] f3);
      logic [1:0] s;
      case (f3)
         3'b000, 3'b100: s = 2'd0;
         3'b001, 3'b101: s = 2'd1;
         3'b011:         s = (XLEN == 64) ? 2'd3 : 2'd2;
         default:        s = 2'd2;
      endcase
      return s;
   endfunction

   // Shift the field to the top, then back down arithmetically or logically.
   function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [2:0] f3);
      logic [XLEN-1:0] r;
      int unsigned     sh;
      logic            sgn;
      case (f3)
         3'b000:  begin sh = XLEN - 8;  sgn = 1'b1; end
         3'b001:  begin sh = XLEN - 16; sgn = 1'b1; end
         3'b011:  begin sh = (XLEN == 64) ? 32'd0 : XLEN - 32; sgn = (XLEN != 64); end
         3'b100:  begin sh = XLEN - 8;  sgn = 1'b0; end
         3'b101:  begin sh = XLEN - 16; sgn = 1'b0; end
         3'b110:  begin sh = XLEN - 32; sgn = 1'b0; end
         default: begin sh = XLEN - 32; sgn = 1'b1; end
      endcase
      r = d << sh;
      if (sgn) r = $signed(r) >>> sh;
      else     r = r >> sh;
      return r;
   endfunction

   logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
   logic [XLEN-1:0]   sb_data_q [SB_DEPTH];
   logic [1:0]        sb_size_q [SB_DEPTH];
   logic [PTR_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q;

   logic is_load, is_store, sb_full, sb_nonempty, push, pop;
   logic ld_issue, ld_fwd;

   logic [ADDR_W-1:0] ld_addr_q;
   logic [1:0]        ld_size_q;
   logic [2:0]        ld_f3_q;
   logic [XLEN-1:0]   ld_data_q;

   assign is_load     = mem_valid_i & ~mem_we_i;
   assign is_store    = mem_valid_i & mem_we_i;
   assign sb_full     = (count_q == CNT_W'(SB_DEPTH));
   assign sb_nonempty = (count_q != '0);
   // Fullness is judged on the registered count, so a same-cycle pop never admits a push.
   assign push        = is_store & ~hold_i & ~sb_full;
   assign pop         = (state_q == StStWait) & resp_valid_i;
   assign sb_empty_o  = ~sb_nonempty;

   logic            fwd_hit;
   logic [XLEN-1:0] fwd_data;

`ifdef LSU_STORE_FWD_EN
   logic [ADDR_W:0]  ld_lo, ld_hi, st_lo, st_hi;
   logic [PTR_W-1:0] fwd_idx;
   logic [1:0]       ld_sz;

   // The youngest overlapping entry decides: forward only if it is an exact match.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = '0;
      st_lo    = '0;
      st_hi    = '0;
      ld_sz    = f3_size(funct3_i);
      ld_lo    = {1'b0, addr_i};
      ld_hi    = ld_lo + ((ADDR_W + 1)'(1) << ld_sz);
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
         if (CNT_W'(i) < count_q) begin
            fwd_idx = head_q + PTR_W'(i);
            st_lo   = {1'b0, sb_addr_q[fwd_idx]};
            st_hi   = st_lo + ((ADDR_W + 1)'(1) << sb_size_q[fwd_idx]);
            if ((ld_lo < st_hi) && (st_lo < ld_hi)) begin
               fwd_hit  = (st_lo == ld_lo) && (sb_size_q[fwd_idx] == ld_sz);
               fwd_data = sb_data_q[fwd_idx];
            end
         end
      end
   end
`else
   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;
`endif

   assign ld_fwd   = (state_q == StIdle) & is_load & fwd_hit;
   assign ld_issue = (state_q == StIdle) & is_load & ~fwd_hit & ~sb_nonempty;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (ld_fwd)           state_d = StLdDone;
            else if (sb_nonempty) state_d = StStReq;
            else if (ld_issue)    state_d = StLdReq;
         end
         StStReq:  if (req_ready_i)  state_d = StStWait;
         StStWait: if (resp_valid_i) state_d = StIdle;
         StLdReq:  if (req_ready_i)  state_d = StLdWait;
         StLdWait: if (resp_valid_i) state_d = StLdDone;
         StLdDone: if (!hold_i)      state_d = StIdle;
         default:                    state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (push) tail_q <= tail_q + PTR_W'(1);
         if (pop)  head_q <= head_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         sb_addr_q[tail_q] <= addr_i;
         sb_data_q[tail_q] <= wdata_i;
         sb_size_q[tail_q] <= f3_size(funct3_i);
      end
   end

   // Load request is captured at issue so it stays stable while memctrl back-pressures.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_addr_q <= '0;
         ld_size_q <= '0;
         ld_f3_q   <= '0;
         ld_data_q <= '0;
      end else begin
         if (ld_issue) begin
            ld_addr_q <= addr_i;
            ld_size_q <= f3_size(funct3_i);
            ld_f3_q   <= funct3_i;
         end
         if (ld_fwd) begin
            ld_data_q <= extend(fwd_data, funct3_i);
         end else if ((state_q == StLdWait) && resp_valid_i) begin
            ld_data_q <= extend(resp_rdata_i, ld_f3_q);
         end
      end
   end

   always_comb begin
      rd_addr_o   = rd_addr_i;
      rd_we_o     = rd_we_i;
      rd_data_o   = rd_data_i;
      stallreq_o  = 1'b0;
      req_valid_o = 1'b0;
      req_we_o    = 1'b0;
      req_addr_o  = '0;
      req_size_o  = '0;
      req_wdata_o = '0;
      if (is_store) begin
         rd_we_o    = 1'b0;
         rd_data_o  = '0;
         stallreq_o = sb_full;
      end else if (is_load) begin
         rd_we_o    = (state_q == StLdDone);
         rd_data_o  = (state_q == StLdDone) ? ld_data_q : '0;
         stallreq_o = (state_q != StLdDone);
      end
      case (state_q)
         StStReq: begin
            req_valid_o = 1'b1;
            req_we_o    = 1'b1;
            req_addr_o  = sb_addr_q[head_q];
            req_size_o  = sb_size_q[head_q];
            req_wdata_o = sb_data_q[head_q];
         end
         StLdReq: begin
            req_valid_o = 1'b1;
            req_addr_o  = ld_addr_q;
            req_size_o  = ld_size_q;
         end
         default: ;
      endcase
      if (rst) begin
         rd_addr_o   = '0;
         rd_we_o     = 1'b0;
         rd_data_o   = '0;
         stallreq_o  = 1'b0;
         req_valid_o = 1'b0;
         req_we_o    = 1'b0;
         req_addr_o  = '0;
         req_size_o  = '0;
         req_wdata_o = '0;
      end
   end

endmodule

// File: tb/tb_mem_lsu_buffered.sv
// Directed bench for mem_lsu_buffered (XLEN=32, SB_DEPTH=4); the bench plays the memctrl side.
module tb_mem_lsu_buffered;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, mem_we, rd_we, hold, req_ready, resp_valid;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata, rd_data, resp_rdata;
   logic [4:0]  rd_addr;
   logic [4:0]  rd_addr_o;
   logic        rd_we_o, stallreq_o, req_valid_o, req_we_o, sb_empty_o;
   logic [31:0] rd_data_o, req_addr_o, req_wdata_o;
   logic [1:0]  req_size_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_lsu_buffered #(.XLEN(32), .ADDR_W(32), .SB_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .mem_valid_i(mem_valid), .mem_we_i(mem_we), .funct3_i(funct3), .addr_i(addr),
      .wdata_i(wdata), .rd_addr_i(rd_addr), .rd_we_i(rd_we), .rd_data_i(rd_data),
      .hold_i(hold), .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .rd_data_o(rd_data_o),
      .stallreq_o(stallreq_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready),
      .req_we_o(req_we_o), .req_addr_o(req_addr_o), .req_size_o(req_size_o),
      .req_wdata_o(req_wdata_o), .resp_valid_i(resp_valid), .resp_rdata_i(resp_rdata),
      .sb_empty_o(sb_empty_o)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      mem_valid = 1'b0; mem_we = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
      rd_addr = '0; rd_we = 1'b0; rd_data = '0; hold = 1'b0;
   endtask

   task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      mem_valid = 1'b1; mem_we = 1'b1; funct3 = f3; addr = a; wdata = d;
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (!req_valid_o && n < 20) begin
         step();
         n++;
      end
      settle();
      chk1("req_valid_within_budget", req_valid_o, 1'b1);
   endtask

   // Accept the head store and ack it one cycle after acceptance.
   task automatic serve_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      wait_req();
      chk1("st_req_we", req_we_o, 1'b1);
      chk32("st_req_addr", req_addr_o, a);
      chk32("st_req_wdata", req_wdata_o, d);
      chk32("st_req_size", 32'(req_size_o), 32'(sz));
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      resp_valid = 1'b1;
      step();
      resp_valid = 1'b0;
      settle();
   endtask

   // Runs a load from IDLE with an empty buffer and stops in the LD_DONE cycle.
   task automatic load_to_done(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdat,
                               input logic [1:0] sz);
      mem_valid = 1'b1; mem_we = 1'b0; funct3 = f3; addr = a;
      settle();
      chk1("ld_stall_on_entry", stallreq_o, 1'b1);
      wait_req();
      chk1("ld_req_we", req_we_o, 1'b0);
      chk32("ld_req_addr", req_addr_o, a);
      chk32("ld_req_size", 32'(req_size_o), 32'(sz));
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      settle();
      chk1("ld_wait_no_req", req_valid_o, 1'b0);
      chk1("ld_wait_stall", stallreq_o, 1'b1);
      resp_valid = 1'b1; resp_rdata = rdat;
      step();
      resp_valid = 1'b0; resp_rdata = '0;
      settle();
      chk1("ld_done_no_stall", stallreq_o, 1'b0);
      chk1("ld_done_we", rd_we_o, 1'b1);
   endtask

   task automatic retire();
      step();
      idle_inputs();
      settle();
   endtask

   logic [2:0]  v_f3   [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b111, 3'b011};
   logic [31:0] v_addr [7] = '{32'h200, 32'h200, 32'h202, 32'h202, 32'h203, 32'h204, 32'h208};
   logic [31:0] v_rd   [7] = '{32'h0000_0080, 32'h0000_0080, 32'h0000_8001, 32'hABCD_8001,
                               32'h1234_567F, 32'h8000_0000, 32'hCAFE_F00D};
   logic [31:0] v_exp  [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                               32'h0000_007F, 32'h8000_0000, 32'hCAFE_F00D};
   logic [1:0]  v_sz   [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
      step();
      step();
      settle();
      chk1("rst_stall", stallreq_o, 1'b0);
      chk1("rst_req_valid", req_valid_o, 1'b0);
      chk1("rst_sb_empty", sb_empty_o, 1'b1);
      chk1("rst_rd_we", rd_we_o, 1'b0);
      chk32("rst_rd_data", rd_data_o, 32'h0);
      rst = 1'b0;
      step();

      // Reset while a load waits for its response; the late response is ignored.
      mem_valid = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h40; req_ready = 1'b1;
      step();
      settle();
      chk1("r1_ld_req", req_valid_o, 1'b1);
      step();
      req_ready = 1'b0;
      settle();
      chk1("r1_ld_wait", req_valid_o, 1'b0);
      chk1("r1_ld_wait_stall", stallreq_o, 1'b1);
      rst = 1'b1;
      settle();
      chk1("r1_rst_stall", stallreq_o, 1'b0);
      step();
      chk1("r1_rst_edge_stall", stallreq_o, 1'b0);
      chk1("r1_rst_edge_req", req_valid_o, 1'b0);
      chk1("r1_rst_edge_empty", sb_empty_o, 1'b1);
      rst = 1'b0;
      idle_inputs();
      step();
      resp_valid = 1'b1; resp_rdata = 32'hAAAA;
      step();
      resp_valid = 1'b0; resp_rdata = '0;
      settle();
      chk1("r1_late_resp_we", rd_we_o, 1'b0);
      chk1("r1_late_resp_req", req_valid_o, 1'b0);
      chk1("r1_late_resp_stall", stallreq_o, 1'b0);

      // Non-memory op passes straight through.
      rd_addr = 5'd7; rd_we = 1'b1; rd_data = 32'h55;
      settle();
      chk32("pass_rd_addr", 32'(rd_addr_o), 32'd7);
      chk1("pass_rd_we", rd_we_o, 1'b1);
      chk32("pass_rd_data", rd_data_o, 32'h55);
      chk1("pass_stall", stallreq_o, 1'b0);
      idle_inputs();
      step();

      // SW 0x100, ready=1, ack two cycles after acceptance.
      req_ready = 1'b1;
      drive_store(32'h100, 32'hDEAD_BEEF, 3'b010);
      settle();
      chk1("sw_no_stall", stallreq_o, 1'b0);
      chk1("sw_rd_we", rd_we_o, 1'b0);
      step();
      idle_inputs();
      settle();
      chk1("sw_buffered", sb_empty_o, 1'b0);
      step();
      settle();
      chk1("sw_req_valid", req_valid_o, 1'b1);
      chk1("sw_req_we", req_we_o, 1'b1);
      chk32("sw_req_addr", req_addr_o, 32'h100);
      chk32("sw_req_size", 32'(req_size_o), 32'd2);
      chk32("sw_req_wdata", req_wdata_o, 32'hDEAD_BEEF);
      step();
      req_ready = 1'b0;
      step();
      resp_valid = 1'b1;
      settle();
      chk1("sw_pending", sb_empty_o, 1'b0);
      step();
      resp_valid = 1'b0;
      settle();
      chk1("sw_drained", sb_empty_o, 1'b1);

      // A store under hold_i is not pushed.
      drive_store(32'h500, 32'h77, 3'b000);
      hold = 1'b1;
      settle();
      chk1("hold_store_stall", stallreq_o, 1'b0);
      step();
      settle();
      chk1("hold_store_not_pushed", sb_empty_o, 1'b1);
      hold = 1'b0;
      step();
      idle_inputs();
      settle();
      chk1("hold_store_pushed", sb_empty_o, 1'b0);
      serve_store(32'h500, 32'h77, 2'd0);

      // Five back-to-back stores into a 4-deep buffer with memctrl stalled.
      req_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive_store(32'h10 + 32'(4 * k), 32'(k + 1), 3'b010);
         settle();
         chk1("fill_no_stall", stallreq_o, 1'b0);
         step();
      end
      drive_store(32'h20, 32'd5, 3'b010);
      settle();
      chk1("full_stall", stallreq_o, 1'b1);
      step();
      settle();
      chk1("full_stall_held", stallreq_o, 1'b1);
      chk32("full_head_addr", req_addr_o, 32'h10);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      resp_valid = 1'b1;
      settle();
      chk1("stall_during_pop", stallreq_o, 1'b1);
      step();
      resp_valid = 1'b0;
      settle();
      chk1("slot_freed", stallreq_o, 1'b0);
      step();
      idle_inputs();
      settle();
      chk1("fifth_pushed", sb_empty_o, 1'b0);
      for (int k = 1; k < 5; k++) begin
         serve_store(32'h10 + 32'(4 * k), 32'(k + 1), 2'd2);
      end
      chk1("fill_drained", sb_empty_o, 1'b1);

      // Load extension vectors.
      for (int i = 0; i < 7; i++) begin
         load_to_done(v_f3[i], v_addr[i], v_rd[i], v_sz[i]);
         chk32("ld_vec_data", rd_data_o, v_exp[i]);
         retire();
      end

      // SH then LH to the same address.
      drive_store(32'h300, 32'h1234, 3'b001);
      step();
      mem_we = 1'b0; funct3 = 3'b001; addr = 32'h300;
      settle();
      chk1("shlh_ld_stall", stallreq_o, 1'b1);
`ifdef LSU_STORE_FWD_EN
      step();
      settle();
      chk1("fwd_rd_we", rd_we_o, 1'b1);
      chk32("fwd_rd_data", rd_data_o, 32'h0000_1234);
      chk1("fwd_no_req", req_valid_o, 1'b0);
      chk1("fwd_no_stall", stallreq_o, 1'b0);
      retire();
      serve_store(32'h300, 32'h1234, 2'd1);
`else
      step();
      settle();
      chk1("shlh_write_first", req_valid_o, 1'b1);
      chk1("shlh_write_we", req_we_o, 1'b1);
      chk32("shlh_write_addr", req_addr_o, 32'h300);
      chk32("shlh_write_size", 32'(req_size_o), 32'd1);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      resp_valid = 1'b1;
      step();
      resp_valid = 1'b0;
      settle();
      chk1("shlh_drained", sb_empty_o, 1'b1);
      chk1("shlh_no_req_yet", req_valid_o, 1'b0);
      chk1("shlh_still_stall", stallreq_o, 1'b1);
      step();
      settle();
      chk1("shlh_read_req", req_valid_o, 1'b1);
      chk1("shlh_read_we", req_we_o, 1'b0);
      chk32("shlh_read_addr", req_addr_o, 32'h300);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      resp_valid = 1'b1; resp_rdata = 32'h1234;
      step();
      resp_valid = 1'b0; resp_rdata = '0;
      settle();
      chk1("shlh_rd_we", rd_we_o, 1'b1);
      chk32("shlh_rd_data", rd_data_o, 32'h0000_1234);
      retire();
`endif
      chk1("shlh_end_empty", sb_empty_o, 1'b1);

      // LD_DONE held for three cycles.
      load_to_done(3'b010, 32'h400, 32'h1122_3344, 2'd2);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         settle();
         chk32("hold_rd_data", rd_data_o, 32'h1122_3344);
         chk1("hold_rd_we", rd_we_o, 1'b1);
         chk1("hold_no_reissue", req_valid_o, 1'b0);
      end
      hold = 1'b0;
      retire();
      chk1("hold_exit_we", rd_we_o, 1'b0);
      chk1("hold_exit_req", req_valid_o, 1'b0);
      step();
      settle();
      chk1("hold_exit_idle", req_valid_o, 1'b0);
      chk1("hold_exit_stall", stallreq_o, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
